// File: rtl/freq_divider_bank_pkg.sv
// Shared constants and helpers for the frequency divider bank.
//   NUM_CH_DEF / CNT_W_DEF : default channel count and counter width
//   RST_PHASE_LEN          : length in clk of the rst_phase pulse after resync
//   ch_w()                 : channel index width for a given channel count
package freq_div_pkg;

  localparam int NUM_CH_DEF    = 4;
  localparam int CNT_W_DEF     = 8;
  localparam int RST_PHASE_LEN = 2;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/freq_divider_bank_if.sv
// Divisor register write bus of the frequency divider bank.
//   wr_en   : write strobe, one clk wide
//   wr_ch   : addressed channel
//   wr_data : new divisor value
// master drives the bus (software side), slave is the divider bank.
interface freq_divider_bank_if
  import freq_div_pkg::*;
#(
  parameter int CH_W  = ch_w(NUM_CH_DEF),
  parameter int CNT_W = CNT_W_DEF
);
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [CNT_W-1:0] wr_data;

  modport master (output wr_en, wr_ch, wr_data);
  modport slave  (input  wr_en, wr_ch, wr_data);
endinterface

// File: rtl/freq_divider_bank_cell.sv
// One CNT_W down-counter slice of the divider bank.
//   load_i/load_val_i : synchronous load, wins over decrement
//   dec_en_i          : counting tick for this slice
//   borrow_in_i       : 1 for a standalone/low slice, low slice borrow for a high slice
//   borrow_out_o      : slice is at zero while decrementing (underflow / carry to high)
// Decrement wraps through zero; the parent decides whether a zero tick reloads.
module freq_div_cell #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_en_i,
  input  logic             borrow_in_i,
  output logic             borrow_out_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dec;

  assign dec          = dec_en_i & borrow_in_i;
  assign borrow_out_o = dec & (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)   cnt_d = load_val_i;
    else if (dec) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/freq_divider_bank.sv
// Bank of NUM_CH programmable dividers; each emits a one-clk timer pulse every
// div+1 ticks of its selected strobe. Channel pairs (2p,2p+1) can be chained
// into one 2*CNT_W divider.
//   clk, rst_n              : clock, async active-low reset
//   tick_base_i/tick_fast_i : clock source strobes
//   fast_sel_i, ch_en_i     : per-channel source select and enable
//   link_i                  : per-pair chaining
//   oneshot_i               : channel stops (active=0) after first underflow
//   resync_i                : reload all counters from div, re-arm all
//   wr                      : divisor write bus (slave)
//   timer_o, active_o       : registered underflow pulses, armed flags
//   rst_phase_o             : RST_PHASE_LEN-clk pulse after resync
module freq_divider_bank
  import freq_div_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int CH_W   = ch_w(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick_base_i,
  input  logic                  tick_fast_i,
  input  logic [NUM_CH-1:0]     fast_sel_i,
  input  logic [NUM_CH/2-1:0]   link_i,
  input  logic [NUM_CH-1:0]     oneshot_i,
  input  logic [NUM_CH-1:0]     ch_en_i,
  input  logic                  resync_i,
  freq_divider_bank_if.slave    wr,
  output logic [NUM_CH-1:0]     timer_o,
  output logic [NUM_CH-1:0]     active_o,
  output logic                  rst_phase_o
);

  localparam int PH_W = $clog2(RST_PHASE_LEN + 1);

  logic [NUM_CH-1:0][CNT_W-1:0] div_q;
  logic [NUM_CH-1:0]            timer_q, timer_d, active_q, active_d;
  logic [PH_W-1:0]              ph_q, ph_d;
  logic [NUM_CH-1:0]            src, wr_hit, stopped, uf, act_set;

  assign src     = (fast_sel_i & {NUM_CH{tick_fast_i}}) | (~fast_sel_i & {NUM_CH{tick_base_i}});
  assign stopped = oneshot_i & ~active_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_hit
    assign wr_hit[i] = wr.wr_en & (wr.wr_ch == CH_W'(i));
  end

  for (genvar p = 0; p < NUM_CH/2; p++) begin : g_pair
    localparam int LO = 2*p;
    localparam int HI = 2*p + 1;
    logic lnk, en_lo, en_hi, rearm_pair, rearm_lo, rearm_hi, bo_lo, bo_hi;

    assign lnk   = link_i[p];
    // A linked pair runs off the low channel's source/enable and the high channel's active.
    assign en_lo = src[LO] & ch_en_i[LO] & (lnk ? active_q[HI] : active_q[LO]);
    assign en_hi = src[HI] & ch_en_i[HI] & active_q[HI];

    // A stopped linked pair is re-armed by a write to either half; the written
    // half takes the new value, the other half its current divisor.
    assign rearm_pair = (wr_hit[LO] | wr_hit[HI]) & stopped[HI];
    assign rearm_lo   = lnk ? rearm_pair : (wr_hit[LO] & stopped[LO]);
    assign rearm_hi   = lnk ? rearm_pair : (wr_hit[HI] & stopped[HI]);

    // Reload values come from div_q, i.e. the divisor before any same-cycle write.
    freq_div_cell #(.CNT_W(CNT_W)) u_lo (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_i       (resync_i | rearm_lo | (lnk ? bo_hi : bo_lo)),
      .load_val_i   ((rearm_lo & wr_hit[LO] & ~resync_i) ? wr.wr_data : div_q[LO]),
      .dec_en_i     (en_lo),
      .borrow_in_i  (1'b1),
      .borrow_out_o (bo_lo)
    );

    freq_div_cell #(.CNT_W(CNT_W)) u_hi (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_i       (resync_i | rearm_hi | bo_hi),
      .load_val_i   ((rearm_hi & wr_hit[HI] & ~resync_i) ? wr.wr_data : div_q[HI]),
      .dec_en_i     (lnk ? en_lo : en_hi),
      .borrow_in_i  (lnk ? bo_lo : 1'b1),
      .borrow_out_o (bo_hi)
    );

    // When linked, bo_hi is the whole-pair underflow.
    assign uf[LO]       = ~lnk & bo_lo;
    assign uf[HI]       = bo_hi;
    assign act_set[LO]  = ~lnk & rearm_lo;
    assign act_set[HI]  = rearm_hi;
    assign active_o[LO] = lnk ? active_q[HI] : active_q[LO];
    assign active_o[HI] = active_q[HI];
  end

  always_comb begin
    timer_d  = resync_i ? '0 : uf;
    active_d = resync_i ? '1 : ((active_q | act_set) & ~(uf & oneshot_i));
    ph_d     = ph_q;
    if (resync_i)        ph_d = PH_W'(RST_PHASE_LEN);
    else if (ph_q != '0) ph_d = ph_q - PH_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      timer_q  <= '0;
      active_q <= '1;
      ph_q     <= '0;
    end else begin
      if (wr.wr_en) div_q[wr.wr_ch] <= wr.wr_data;
      timer_q  <= timer_d;
      active_q <= active_d;
      ph_q     <= ph_d;
    end
  end

  assign timer_o     = timer_q;
  assign rst_phase_o = (ph_q != '0);

endmodule

// File: tb/tb_freq_divider_bank.sv
module tb_freq_divider_bank;

  logic       clk, rst_n, tick_base, tick_fast, resync, rst_phase;
  logic [3:0] fast_sel, oneshot, ch_en, timer, active;
  logic [1:0] link;

  freq_divider_bank_if #(.CH_W(2), .CNT_W(8)) bus ();

  freq_divider_bank #(.NUM_CH(4), .CNT_W(8), .CH_W(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_base_i (tick_base),
    .tick_fast_i (tick_fast),
    .fast_sel_i  (fast_sel),
    .link_i      (link),
    .oneshot_i   (oneshot),
    .ch_en_i     (ch_en),
    .resync_i    (resync),
    .wr          (bus.slave),
    .timer_o     (timer),
    .active_o    (active),
    .rst_phase_o (rst_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain integer counters; a linked pair is one integer.
  int       m_div[4];
  int       m_cnt[4];
  bit [3:0] m_act;
  bit [3:0] m_tmr;
  int       m_ph;

  int pulses[$];
  int zero_hits;

  typedef struct {
    logic       tb;
    logic       rs;
    logic [3:0] et;
    logic       eph;
  } vec_t;
  vec_t vt[9];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_div[i] = 0;
      m_cnt[i] = 0;
    end
    m_act = 4'hf;
    m_tmr = 4'h0;
    m_ph  = 0;
  endtask

  task automatic model_step();
    bit [3:0] t;
    t = 4'h0;
    for (int p = 0; p < 2; p++) begin
      int lo, hi, c, d;
      bit s;
      lo = 2*p;
      hi = 2*p + 1;
      if (resync) begin
        m_cnt[lo] = m_div[lo];
        m_cnt[hi] = m_div[hi];
        m_act[lo] = 1'b1;
        m_act[hi] = 1'b1;
      end else if (!link[p]) begin
        for (int i = lo; i <= hi; i++) begin
          s = fast_sel[i] ? tick_fast : tick_base;
          if (bus.wr_en && bus.wr_ch == i && oneshot[i] && !m_act[i]) begin
            m_act[i] = 1'b1;
            m_cnt[i] = int'(bus.wr_data);
          end else if (s && ch_en[i] && m_act[i]) begin
            if (m_cnt[i] == 0) begin
              m_cnt[i] = m_div[i];
              t[i] = 1'b1;
              if (oneshot[i]) m_act[i] = 1'b0;
            end else m_cnt[i]--;
          end
        end
      end else begin
        c = m_cnt[hi]*256 + m_cnt[lo];
        d = m_div[hi]*256 + m_div[lo];
        s = fast_sel[lo] ? tick_fast : tick_base;
        if (bus.wr_en && (bus.wr_ch == lo || bus.wr_ch == hi) && oneshot[hi] && !m_act[hi]) begin
          m_act[hi] = 1'b1;
          m_cnt[lo] = (bus.wr_ch == lo) ? int'(bus.wr_data) : m_div[lo];
          m_cnt[hi] = (bus.wr_ch == hi) ? int'(bus.wr_data) : m_div[hi];
        end else begin
          if (s && ch_en[lo] && m_act[hi]) begin
            if (c == 0) begin
              c = d;
              t[hi] = 1'b1;
              if (oneshot[hi]) m_act[hi] = 1'b0;
            end else c--;
          end
          m_cnt[lo] = c % 256;
          m_cnt[hi] = c / 256;
        end
      end
    end
    if (bus.wr_en) m_div[bus.wr_ch] = int'(bus.wr_data);
    m_tmr = t;
    m_ph  = resync ? 2 : ((m_ph > 0) ? m_ph - 1 : 0);
  endtask

  function automatic logic [3:0] exp_act();
    logic [3:0] a;
    for (int p = 0; p < 2; p++) begin
      a[2*p]   = link[p] ? m_act[2*p+1] : m_act[2*p];
      a[2*p+1] = m_act[2*p+1];
    end
    return a;
  endfunction

  // One clock: model advances with the inputs seen at the edge, outputs checked 1 after.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("timer", 32'(timer), 32'(m_tmr));
    chk("active", 32'(active), 32'(exp_act()));
    chk("rst_phase", 32'(rst_phase), 32'(m_ph != 0));
    bus.wr_en = 1'b0;
    resync    = 1'b0;
  endtask

  task automatic wr(input int ch, input int d);
    bus.wr_en   = 1'b1;
    bus.wr_ch   = 2'(ch);
    bus.wr_data = 8'(d);
    tick_base   = 1'b0;
    cycle();
  endtask

  task automatic do_resync();
    resync    = 1'b1;
    tick_base = 1'b0;
    cycle();
  endtask

  task automatic measure(input int ncyc, input int every, input int bitn);
    pulses.delete();
    zero_hits = 0;
    for (int k = 0; k < ncyc; k++) begin
      tick_base = (k % every == 0);
      cycle();
      if (timer[bitn]) pulses.push_back(k);
      if (timer[0]) zero_hits++;
    end
    tick_base = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{1'b0, 1'b1, 4'b0000, 1'b1};
    vt[1] = '{1'b1, 1'b0, 4'b0100, 1'b1};
    vt[2] = '{1'b0, 1'b0, 4'b0000, 1'b0};
    vt[3] = '{1'b1, 1'b0, 4'b0101, 1'b0};
    vt[4] = '{1'b1, 1'b0, 4'b0110, 1'b0};
    vt[5] = '{1'b1, 1'b0, 4'b1101, 1'b0};
    vt[6] = '{1'b1, 1'b1, 4'b0000, 1'b1};
    vt[7] = '{1'b0, 1'b0, 4'b0000, 1'b1};
    vt[8] = '{1'b1, 1'b0, 4'b0100, 1'b0};

    rst_n = 1'b0; tick_base = 1'b0; tick_fast = 1'b0; resync = 1'b0;
    fast_sel = 4'h0; link = 2'b00; oneshot = 4'h0; ch_en = 4'hf;
    bus.wr_en = 1'b0; bus.wr_ch = 2'd0; bus.wr_data = 8'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset timer", 32'(timer), 32'h0);
    chk("reset active", 32'(active), 32'hf);
    chk("reset rst_phase", 32'(rst_phase), 32'h0);
    rst_n = 1'b1;

    // Table: divisors 1,2,0,3; resync, ticks, resync coinciding with underflow.
    wr(0, 1); wr(1, 2); wr(2, 0); wr(3, 3);
    foreach (vt[i]) begin
      tick_base = vt[i].tb;
      resync    = vt[i].rs;
      cycle();
      chk($sformatf("vec%0d timer", i), 32'(timer), 32'(vt[i].et));
      chk($sformatf("vec%0d rst_phase", i), 32'(rst_phase), 32'(vt[i].eph));
    end
    tick_base = 1'b0;

    // div[0]=3, tick every 4 clk -> pulse every 16 clk.
    wr(0, 3); do_resync();
    measure(70, 4, 0);
    chk("t1 first pulse", 32'((pulses.size() > 0) ? pulses[0] : -1), 32'd12);
    chk("t1 period", 32'((pulses.size() > 1) ? pulses[1] - pulses[0] : -1), 32'd16);

    // Linked pair 0 with 0x0102 -> period 259, timer[0] silent.
    link = 2'b01;
    wr(0, 2); wr(1, 1); do_resync();
    measure(600, 1, 1);
    chk("t2 first pulse", 32'((pulses.size() > 0) ? pulses[0] : -1), 32'd258);
    chk("t2 period", 32'((pulses.size() > 1) ? pulses[1] - pulses[0] : -1), 32'd259);
    chk("t2 low silent", 32'(zero_hits), 32'd0);
    link = 2'b00;

    // One-shot channel 2.
    oneshot = 4'b0100;
    wr(2, 5); do_resync();
    measure(10, 1, 2);
    chk("t3 pulse tick", 32'((pulses.size() > 0) ? pulses[0] : -1), 32'd5);
    chk("t3 single pulse", 32'(pulses.size()), 32'd1);
    chk("t3 stopped", 32'(active[2]), 32'd0);
    wr(2, 1);
    chk("t3 rearmed", 32'(active[2]), 32'd1);
    measure(5, 1, 2);
    chk("t3 rearm pulse", 32'((pulses.size() > 0) ? pulses[0] : -1), 32'd1);
    oneshot = 4'b0000;
    do_resync();

    // Write div[0]=9 during the div=2 underflow: next period 3, then 10.
    wr(0, 2); do_resync();
    pulses.delete();
    for (int k = 0; k < 20; k++) begin
      tick_base = 1'b1;
      if (k == 2) begin
        bus.wr_en = 1'b1; bus.wr_ch = 2'd0; bus.wr_data = 8'd9;
      end
      cycle();
      if (timer[0]) pulses.push_back(k);
    end
    chk("t4 pulse count", 32'(pulses.size() >= 3), 32'd1);
    if (pulses.size() >= 3) begin
      chk("t4 old div pulse", 32'(pulses[0]), 32'd2);
      chk("t4 old div reload", 32'(pulses[1]), 32'd5);
      chk("t4 new div", 32'(pulses[2]), 32'd15);
    end

    // Reset mid-count while timer and rst_phase are high.
    wr(2, 0); do_resync();
    tick_base = 1'b1;
    cycle();
    rst_n = 1'b0;
    #1;
    chk("t6 timer drop", 32'(timer), 32'h0);
    chk("t6 rst_phase drop", 32'(rst_phase), 32'h0);
    chk("t6 active", 32'(active), 32'hf);
    model_reset();
    tick_base = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick_base = 1'b1;
      cycle();
      chk("t6 every tick", 32'(timer), 32'hf);
    end

    // Randomised traffic against the model.
    for (int k = 0; k < 2500; k++) begin
      tick_base = ($urandom_range(0, 2) == 0);
      tick_fast = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0)  fast_sel = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) link     = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0)  oneshot  = 4'($urandom_range(0, 15));
      ch_en = 4'hf;
      if ($urandom_range(0, 9) == 0) ch_en = 4'($urandom_range(0, 15));
      resync = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 7) == 0) begin
        bus.wr_en   = 1'b1;
        bus.wr_ch   = 2'($urandom_range(0, 3));
        bus.wr_data = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                  : 8'($urandom_range(0, 6));
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
